// File: rtl/control_sequencer_pkg.sv
// Shared types for the hardwired control sequencer: opcodes, state encoding,
// instruction classes and the control word that drives the datapath.
package control_sequencer_pkg;

  localparam int IR_W = 32;
  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10101;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10110;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  localparam logic [OP_W-1:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU3, C_ALUI, C_MULDIV, C_UNARY,
    C_BR, C_JR, C_JAL, C_IO, C_MV, C_NOP, C_HALT
  } iclass_t;

  typedef struct packed {
    logic            Run;
    logic [OP_W-1:0] ALU_op;
    logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out;
    logic MAR_enable, MDR_enable, IR_enable, Y_enable, ZLowIn, ZHighIn, PC_enable;
    logic HI_enable, LO_enable, OutPort_enable, CON_enable, R_in;
    logic IncPC, MDR_read, RAM_write, Gra, Grb, Grc;
  } ctrl_t;

  // Index of the final execute step for each class; fetch-only classes end at T2.
  function automatic logic [2:0] last_step(iclass_t c);
    case (c)
      C_LD, C_ST:           last_step = 3'd7;
      C_MULDIV, C_BR:       last_step = 3'd6;
      C_LDI, C_ALU3, C_ALUI: last_step = 3'd5;
      C_UNARY, C_JAL:       last_step = 3'd4;
      C_JR, C_IO, C_MV:     last_step = 3'd3;
      default:              last_step = 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Datapath-side control bundle: instruction/flag inputs and every control line.
// Mem_ready exists only when MEM_WAIT_EN is defined.
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  logic [IR_W-1:0] IR;
  logic            branch_flag;
`ifdef MEM_WAIT_EN
  logic            Mem_ready;
`endif
  logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out;
  logic MAR_enable, MDR_enable, IR_enable, Y_enable, ZLowIn, ZHighIn, PC_enable;
  logic HI_enable, LO_enable, OutPort_enable, CON_enable, R_in;
  logic IncPC, MDR_read, RAM_write, Gra, Grb, Grc;
  logic [OP_W-1:0] ALU_op;
  logic            Run;

  modport master (
`ifdef MEM_WAIT_EN
    input  Mem_ready,
`endif
    input  IR, branch_flag,
    output PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out,
    output MAR_enable, MDR_enable, IR_enable, Y_enable, ZLowIn, ZHighIn, PC_enable,
    output HI_enable, LO_enable, OutPort_enable, CON_enable, R_in,
    output IncPC, MDR_read, RAM_write, Gra, Grb, Grc, ALU_op, Run
  );

  modport slave (
`ifdef MEM_WAIT_EN
    output Mem_ready,
`endif
    output IR, branch_flag,
    input  PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout, R_out,
    input  MAR_enable, MDR_enable, IR_enable, Y_enable, ZLowIn, ZHighIn, PC_enable,
    input  HI_enable, LO_enable, OutPort_enable, CON_enable, R_in,
    input  IncPC, MDR_read, RAM_write, Gra, Grb, Grc, ALU_op, Run
  );

endinterface

// File: rtl/control_sequencer_decode.sv
// Combinational opcode-to-instruction-class map; unknown opcodes behave as nop.
module control_sequencer_decode
  import control_sequencer_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output iclass_t         iclass
);

  always_comb begin
    iclass = C_NOP;
    case (op)
      OP_LD:                        iclass = C_LD;
      OP_LDI:                       iclass = C_LDI;
      OP_ST:                        iclass = C_ST;
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR: iclass = C_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI:     iclass = C_ALUI;
      OP_MUL, OP_DIV:               iclass = C_MULDIV;
      OP_NEG, OP_NOT:               iclass = C_UNARY;
      OP_BR:                        iclass = C_BR;
      OP_JR:                        iclass = C_JR;
      OP_JAL:                       iclass = C_JAL;
      OP_IN, OP_OUT:                iclass = C_IO;
      OP_MFHI, OP_MFLO:             iclass = C_MV;
      OP_HALT:                      iclass = C_HALT;
      OP_NOP:                       iclass = C_NOP;
      default:                      iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, decode, per-class execute steps.
// Outputs are registered from the next state. MEM_WAIT_EN adds Mem_ready stalls.
//
// state    | meaning
// RESET    | held in reset, all outputs 0
// T0-T2    | instruction fetch
// T3-T7    | execute steps of the latched opcode
// HALT     | stopped until Clear
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic              Clock,
  input  logic              Clear,
  control_sequencer_if.master bus
);

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_sel;
  iclass_t         iclass;
  ctrl_t           ctrl_q, ctrl_d;
  logic [2:0]      step;
  logic            mem_ready, mem_hold;
  logic            unused_ir;

`ifdef MEM_WAIT_EN
  assign mem_ready = bus.Mem_ready;
`else
  assign mem_ready = 1'b1;
`endif

  assign unused_ir = ^bus.IR[IR_W-OP_W-1:0];

  // In T2 the opcode comes straight from IR so the T3 decision and T3 outputs see it.
  assign op_sel = (state_q == ST_T2) ? bus.IR[IR_W-1:IR_W-OP_W] : op_q;

  control_sequencer_decode u_decode (
    .op     (op_sel),
    .iclass (iclass)
  );

  always_comb begin
    step = 3'd0;
    case (state_q)
      ST_T3:   step = 3'd3;
      ST_T4:   step = 3'd4;
      ST_T5:   step = 3'd5;
      ST_T6:   step = 3'd6;
      ST_T7:   step = 3'd7;
      default: step = 3'd0;
    endcase
  end

  assign mem_hold = ~mem_ready & (((state_q == ST_T6) && (iclass == C_LD)) ||
                                  ((state_q == ST_T7) && (iclass == C_ST)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    state_d = ST_T1;
      ST_T1:    if (mem_ready) state_d = ST_T2;
      ST_T2: begin
        case (iclass)
          C_NOP:   state_d = ST_T0;
          C_HALT:  state_d = ST_HALT;
          default: state_d = ST_T3;
        endcase
      end
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        if (!mem_hold) begin
          if ((step >= last_step(iclass)) || (state_q == ST_T7))
            state_d = ST_T0;
          else
            state_d = state_t'(state_q + 4'd1);
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    ctrl_d.Run = (state_d != ST_RESET) && (state_d != ST_HALT);
    case (state_d)
      ST_T0: begin
        ctrl_d.PCout = 1'b1; ctrl_d.MAR_enable = 1'b1; ctrl_d.IncPC = 1'b1; ctrl_d.ZLowIn = 1'b1;
      end
      ST_T1: begin
        ctrl_d.ZLowout = 1'b1; ctrl_d.PC_enable = 1'b1;
        ctrl_d.MDR_read = 1'b1; ctrl_d.MDR_enable = 1'b1;
      end
      ST_T2: begin
        ctrl_d.MDRout = 1'b1; ctrl_d.IR_enable = 1'b1;
      end
      ST_T3: begin
        case (iclass)
          C_LD, C_LDI, C_ST: begin
            ctrl_d.Grb = 1'b1; ctrl_d.BAout = 1'b1; ctrl_d.Y_enable = 1'b1;
          end
          C_ALU3, C_ALUI: begin
            ctrl_d.Grb = 1'b1; ctrl_d.R_out = 1'b1; ctrl_d.Y_enable = 1'b1;
          end
          C_MULDIV: begin
            ctrl_d.Gra = 1'b1; ctrl_d.R_out = 1'b1; ctrl_d.Y_enable = 1'b1;
          end
          C_UNARY: begin
            ctrl_d.Grb = 1'b1; ctrl_d.R_out = 1'b1; ctrl_d.ZLowIn = 1'b1; ctrl_d.ALU_op = op_sel;
          end
          C_BR: begin
            ctrl_d.Gra = 1'b1; ctrl_d.R_out = 1'b1; ctrl_d.CON_enable = 1'b1;
          end
          C_JR: begin
            ctrl_d.Gra = 1'b1; ctrl_d.R_out = 1'b1; ctrl_d.PC_enable = 1'b1;
          end
          C_JAL: begin
            ctrl_d.PCout = 1'b1; ctrl_d.Grb = 1'b1; ctrl_d.R_in = 1'b1;
          end
          C_IO: begin
            ctrl_d.Gra = 1'b1;
            if (op_sel == OP_IN) begin
              ctrl_d.InPortout = 1'b1; ctrl_d.R_in = 1'b1;
            end else begin
              ctrl_d.R_out = 1'b1; ctrl_d.OutPort_enable = 1'b1;
            end
          end
          C_MV: begin
            ctrl_d.Gra = 1'b1; ctrl_d.R_in = 1'b1;
            if (op_sel == OP_MFHI) ctrl_d.HIout = 1'b1;
            else                   ctrl_d.LOout = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (iclass)
          C_LD, C_LDI, C_ST: begin
            ctrl_d.Cout = 1'b1; ctrl_d.ZLowIn = 1'b1; ctrl_d.ALU_op = ALU_ADD;
          end
          C_ALU3: begin
            ctrl_d.Grc = 1'b1; ctrl_d.R_out = 1'b1; ctrl_d.ZLowIn = 1'b1; ctrl_d.ALU_op = op_sel;
          end
          C_ALUI: begin
            ctrl_d.Cout = 1'b1; ctrl_d.ZLowIn = 1'b1; ctrl_d.ALU_op = op_sel;
          end
          C_MULDIV: begin
            ctrl_d.Grb = 1'b1; ctrl_d.R_out = 1'b1; ctrl_d.ZLowIn = 1'b1;
            ctrl_d.ZHighIn = 1'b1; ctrl_d.ALU_op = op_sel;
          end
          C_UNARY: begin
            ctrl_d.ZLowout = 1'b1; ctrl_d.Gra = 1'b1; ctrl_d.R_in = 1'b1;
          end
          C_BR: begin
            ctrl_d.PCout = 1'b1; ctrl_d.Y_enable = 1'b1;
          end
          C_JAL: begin
            ctrl_d.Gra = 1'b1; ctrl_d.R_out = 1'b1; ctrl_d.PC_enable = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (iclass)
          C_LD, C_ST: begin
            ctrl_d.ZLowout = 1'b1; ctrl_d.MAR_enable = 1'b1;
          end
          C_LDI, C_ALU3, C_ALUI: begin
            ctrl_d.ZLowout = 1'b1; ctrl_d.Gra = 1'b1; ctrl_d.R_in = 1'b1;
          end
          C_MULDIV: begin
            ctrl_d.ZLowout = 1'b1; ctrl_d.LO_enable = 1'b1;
          end
          C_BR: begin
            ctrl_d.Cout = 1'b1; ctrl_d.ZLowIn = 1'b1; ctrl_d.ALU_op = ALU_ADD;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (iclass)
          C_LD: begin
            ctrl_d.MDR_read = 1'b1; ctrl_d.MDR_enable = 1'b1;
          end
          C_ST: begin
            ctrl_d.Gra = 1'b1; ctrl_d.R_out = 1'b1; ctrl_d.MDR_enable = 1'b1;
          end
          C_MULDIV: begin
            ctrl_d.ZHighout = 1'b1; ctrl_d.HI_enable = 1'b1;
          end
          C_BR: begin
            // Not-taken branch spends this cycle idle rather than skipping it.
            if (bus.branch_flag) begin
              ctrl_d.ZLowout = 1'b1; ctrl_d.PC_enable = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_T7: begin
        case (iclass)
          C_LD: begin
            ctrl_d.MDRout = 1'b1; ctrl_d.Gra = 1'b1; ctrl_d.R_in = 1'b1;
          end
          C_ST: ctrl_d.RAM_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= ST_RESET;
      op_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      if (state_q == ST_T2) op_q <= op_sel;
    end
  end

  assign bus.Run            = ctrl_q.Run;
  assign bus.ALU_op         = ctrl_q.ALU_op;
  assign bus.PCout          = ctrl_q.PCout;
  assign bus.ZLowout        = ctrl_q.ZLowout;
  assign bus.ZHighout       = ctrl_q.ZHighout;
  assign bus.MDRout         = ctrl_q.MDRout;
  assign bus.HIout          = ctrl_q.HIout;
  assign bus.LOout          = ctrl_q.LOout;
  assign bus.InPortout      = ctrl_q.InPortout;
  assign bus.Cout           = ctrl_q.Cout;
  assign bus.BAout          = ctrl_q.BAout;
  assign bus.R_out          = ctrl_q.R_out;
  assign bus.MAR_enable     = ctrl_q.MAR_enable;
  assign bus.MDR_enable     = ctrl_q.MDR_enable;
  assign bus.IR_enable      = ctrl_q.IR_enable;
  assign bus.Y_enable       = ctrl_q.Y_enable;
  assign bus.ZLowIn         = ctrl_q.ZLowIn;
  assign bus.ZHighIn        = ctrl_q.ZHighIn;
  assign bus.PC_enable      = ctrl_q.PC_enable;
  assign bus.HI_enable      = ctrl_q.HI_enable;
  assign bus.LO_enable      = ctrl_q.LO_enable;
  assign bus.OutPort_enable = ctrl_q.OutPort_enable;
  assign bus.CON_enable     = ctrl_q.CON_enable;
  assign bus.R_in           = ctrl_q.R_in;
  assign bus.IncPC          = ctrl_q.IncPC;
  assign bus.MDR_read       = ctrl_q.MDR_read;
  assign bus.RAM_write      = ctrl_q.RAM_write;
  assign bus.Gra            = ctrl_q.Gra;
  assign bus.Grb            = ctrl_q.Grb;
  assign bus.Grc            = ctrl_q.Grc;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-step control words against hand-built masks.
module tb_control_sequencer;

  logic Clock;
  logic Clear;
  int   n_checks = 0;
  int   n_fail   = 0;

  control_sequencer_if bus ();

  control_sequencer dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [27:0] M_PCOUT   = 28'd1 << 0;
  localparam logic [27:0] M_ZLOUT   = 28'd1 << 1;
  localparam logic [27:0] M_ZHOUT   = 28'd1 << 2;
  localparam logic [27:0] M_MDROUT  = 28'd1 << 3;
  localparam logic [27:0] M_HIOUT   = 28'd1 << 4;
  localparam logic [27:0] M_LOOUT   = 28'd1 << 5;
  localparam logic [27:0] M_INPOUT  = 28'd1 << 6;
  localparam logic [27:0] M_COUT    = 28'd1 << 7;
  localparam logic [27:0] M_BAOUT   = 28'd1 << 8;
  localparam logic [27:0] M_ROUT    = 28'd1 << 9;
  localparam logic [27:0] M_MAREN   = 28'd1 << 10;
  localparam logic [27:0] M_MDREN   = 28'd1 << 11;
  localparam logic [27:0] M_IREN    = 28'd1 << 12;
  localparam logic [27:0] M_YEN     = 28'd1 << 13;
  localparam logic [27:0] M_ZLIN    = 28'd1 << 14;
  localparam logic [27:0] M_ZHIN    = 28'd1 << 15;
  localparam logic [27:0] M_PCEN    = 28'd1 << 16;
  localparam logic [27:0] M_HIEN    = 28'd1 << 17;
  localparam logic [27:0] M_LOEN    = 28'd1 << 18;
  localparam logic [27:0] M_OUTPEN  = 28'd1 << 19;
  localparam logic [27:0] M_CONEN   = 28'd1 << 20;
  localparam logic [27:0] M_RIN     = 28'd1 << 21;
  localparam logic [27:0] M_INCPC   = 28'd1 << 22;
  localparam logic [27:0] M_MDRRD   = 28'd1 << 23;
  localparam logic [27:0] M_RAMWR   = 28'd1 << 24;
  localparam logic [27:0] M_GRA     = 28'd1 << 25;
  localparam logic [27:0] M_GRB     = 28'd1 << 26;
  localparam logic [27:0] M_GRC     = 28'd1 << 27;

  localparam logic [27:0] F0 = M_PCOUT | M_MAREN | M_INCPC | M_ZLIN;
  localparam logic [27:0] F1 = M_ZLOUT | M_PCEN | M_MDRRD | M_MDREN;
  localparam logic [27:0] F2 = M_MDROUT | M_IREN;

  localparam logic [4:0] A_ADD = 5'b00011;

  logic [33:0] obs;
  assign obs = {bus.Run, bus.ALU_op,
                bus.Grc, bus.Grb, bus.Gra, bus.RAM_write, bus.MDR_read, bus.IncPC,
                bus.R_in, bus.CON_enable, bus.OutPort_enable, bus.LO_enable, bus.HI_enable,
                bus.PC_enable, bus.ZHighIn, bus.ZLowIn, bus.Y_enable, bus.IR_enable,
                bus.MDR_enable, bus.MAR_enable, bus.R_out, bus.BAout, bus.Cout,
                bus.InPortout, bus.LOout, bus.HIout, bus.MDRout, bus.ZHighout,
                bus.ZLowout, bus.PCout};

  logic [33:0] exp_q[$];

  function automatic logic [33:0] w(input logic [4:0] alu, input logic [27:0] m);
    return {1'b1, alu, m};
  endfunction

  task automatic chk_val(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Starts in T0; checks every step, then corrupts IR once in T3 to prove the opcode is latched.
  task automatic run_seq(input logic [31:0] ir, input logic flag, input string name);
    bus.IR = ir;
    bus.branch_flag = flag;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_val($sformatf("%s_t%0d", name, i), obs, exp_q[i]);
      if (i == 3) bus.IR = 32'hFFFF_FFFF;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Clear = 1'b0;
    bus.IR = 32'h0;
    bus.branch_flag = 1'b0;
`ifdef MEM_WAIT_EN
    bus.Mem_ready = 1'b1;
`endif
    #1;
    chk_val("reset_init", obs, 34'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_val($sformatf("reset_hold%0d", i), obs, 34'h0);
    end
    Clear = 1'b1;
    step();
    chk_val("reset_t0", obs, w(5'd0, F0));

    exp_q = {w(0, F0), w(0, F1), w(0, F2), w(0, M_GRB | M_BAOUT | M_YEN),
             w(A_ADD, M_COUT | M_ZLIN), w(0, M_ZLOUT | M_MAREN),
             w(0, M_MDRRD | M_MDREN), w(0, M_MDROUT | M_GRA | M_RIN)};
    run_seq(32'h0090_0054, 1'b0, "ld");

    exp_q = {w(0, F0), w(0, F1), w(0, F2), w(0, M_GRB | M_ROUT | M_YEN),
             w(A_ADD, M_GRC | M_ROUT | M_ZLIN), w(0, M_ZLOUT | M_GRA | M_RIN)};
    run_seq(32'h19A2_8000, 1'b0, "add");

    exp_q = {w(0, F0), w(0, F1), w(0, F2), w(0, M_GRA | M_ROUT | M_CONEN),
             w(0, M_PCOUT | M_YEN), w(A_ADD, M_COUT | M_ZLIN), w(0, 28'd0)};
    run_seq(32'h9000_0000, 1'b0, "br_nt");

    exp_q[6] = w(0, M_ZLOUT | M_PCEN);
    run_seq(32'h9000_0000, 1'b1, "br_tk");

    exp_q = {w(0, F0), w(0, F1), w(0, F2), w(0, M_GRB | M_BAOUT | M_YEN),
             w(A_ADD, M_COUT | M_ZLIN), w(0, M_ZLOUT | M_MAREN),
             w(0, M_GRA | M_ROUT | M_MDREN), w(0, M_RAMWR)};
    run_seq(32'h1000_0000, 1'b0, "st");

    exp_q = {w(0, F0), w(0, F1), w(0, F2), w(0, M_GRA | M_ROUT | M_YEN),
             w(5'b01110, M_GRB | M_ROUT | M_ZLIN | M_ZHIN),
             w(0, M_ZLOUT | M_LOEN), w(0, M_ZHOUT | M_HIEN)};
    run_seq(32'h7000_0000, 1'b0, "mul");

    exp_q = {w(0, F0), w(0, F1), w(0, F2), w(5'b10000, M_GRB | M_ROUT | M_ZLIN),
             w(0, M_ZLOUT | M_GRA | M_RIN)};
    run_seq(32'h8000_0000, 1'b0, "neg");

    exp_q = {w(0, F0), w(0, F1), w(0, F2), w(0, M_PCOUT | M_GRB | M_RIN),
             w(0, M_GRA | M_ROUT | M_PCEN)};
    run_seq(32'hA000_0000, 1'b0, "jal");

    exp_q = {w(0, F0), w(0, F1), w(0, F2), w(0, M_GRB | M_ROUT | M_YEN),
             w(5'b01011, M_COUT | M_ZLIN), w(0, M_ZLOUT | M_GRA | M_RIN)};
    run_seq(32'h5800_0000, 1'b0, "addi");

    exp_q = {w(0, F0), w(0, F1), w(0, F2), w(0, M_INPOUT | M_GRA | M_RIN)};
    run_seq(32'hA800_0000, 1'b0, "in");

    exp_q = {w(0, F0), w(0, F1), w(0, F2), w(0, M_LOOUT | M_GRA | M_RIN)};
    run_seq(32'hC000_0000, 1'b0, "mflo");

    exp_q = {w(0, F0), w(0, F1), w(0, F2)};
    run_seq(32'hC800_0000, 1'b0, "nop");
    run_seq(32'hF800_0000, 1'b0, "undef");

    // Abort mid-instruction: ld reaches T4, then Clear drops between edges.
    bus.IR = 32'h0090_0054;
    for (int i = 0; i < 4; i++) step();
    chk_val("abort_pre", obs, w(A_ADD, M_COUT | M_ZLIN));
    #2 Clear = 1'b0;
    #1;
    chk_val("abort_async", obs, 34'h0);
    step();
    chk_val("abort_hold", obs, 34'h0);
    Clear = 1'b1;
    step();
    chk_val("abort_t0", obs, w(0, F0));

    bus.IR = 32'hD000_0000;
    step();
    step();
    chk_val("halt_t2", obs, w(0, F2));
    for (int i = 0; i < 20; i++) begin
      step();
      chk_val($sformatf("halt_c%0d", i), obs, 34'h0);
    end
    Clear = 1'b0;
    step();
    Clear = 1'b1;
    step();
    chk_val("halt_exit_t0", obs, w(0, F0));

`ifdef MEM_WAIT_EN
    bus.IR = 32'h0090_0054;
    bus.Mem_ready = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk_val($sformatf("wait_t1_%0d", k), obs, w(0, F1));
      if (k == 3) bus.Mem_ready = 1'b1;
      step();
    end
    chk_val("wait_t2", obs, w(0, F2));
    for (int i = 0; i < 6; i++) step();
    chk_val("wait_back_t0", obs, w(0, F0));
    bus.Mem_ready = 1'b0;
    step();
    step();
    chk_val("wait_abort_pre", obs, w(0, F1));
    #2 Clear = 1'b0;
    #1;
    chk_val("wait_abort", obs, 34'h0);
    bus.Mem_ready = 1'b1;
    step();
    Clear = 1'b1;
    step();
    chk_val("wait_abort_t0", obs, w(0, F0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
